// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: byte-lane stores, aligned word reads,
// programmable wait states with a stall handshake, and range/alignment fault pulses.
module dmem_responder #(
    parameter int ADDR_WORDS  = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    output logic [31:0] data_read_fDM,
    output logic        stall_2MEM,
    output logic        addr_err,
    output logic        align_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    localparam int AW = $clog2(ADDR_WORDS);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cntNext;
    logic [31:0]   r_mem [ADDR_WORDS];
    logic          r_addrErr;
    logic          r_alignErr;
    logic [31:0]   r_rdCount;
    logic [31:0]   r_wrCount;

    logic          w_req;
    logic          w_oor;
    logic          w_complete;
    logic          w_stall;
    logic          w_commit;
    logic          w_crossEnd;
    logic [AW-1:0] w_index;
    logic [1:0]    w_offset;
    logic [2:0]    w_size;
    logic [31:0]   w_wrData;
    logic [31:0]   w_wrMask;

    assign w_req      = MemRead_2DM | MemWrite_2DM;
    assign w_oor      = (data_address_2DM >> (AW + 2)) != 32'd0;
    assign w_index    = data_address_2DM[AW+1:2];
    assign w_offset   = data_address_2DM[1:0];
    assign w_size     = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
    assign w_crossEnd = ({1'b0, w_offset} + w_size) > 3'd4;

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_complete  = 1'b0;
        w_stall     = 1'b0;
        if (WAIT_CYCLES == 0) begin
            w_complete = w_req;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        w_stateNext = S_WAIT;
                        w_cntNext   = WAIT_LOAD;
                        w_stall     = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!w_req) begin
                        w_stateNext = S_IDLE;
                    end else if (r_cnt == 4'd0) begin
                        w_complete  = 1'b1;
                        w_stateNext = S_IDLE;
                    end else begin
                        w_cntNext = r_cnt - 4'd1;
                        w_stall   = 1'b1;
                    end
                end
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    // Field byte j (j=0 most significant of the k-byte field) lands in lane offset+j.
    always_comb begin
        w_wrData = '0;
        w_wrMask = '0;
        for (int lane = 0; lane < 4; lane++) begin
            if (lane >= int'(w_offset) && lane < int'(w_offset) + int'(w_size)) begin
                w_wrData[8*(3-lane) +: 8] =
                    data_write_2DM[8*(int'(w_size) - 1 - lane + int'(w_offset)) +: 8];
                w_wrMask[8*(3-lane) +: 8] = 8'hFF;
            end
        end
    end

    assign w_commit = w_complete & MemWrite_2DM & ~w_oor & ~RESET;

    always_ff @(posedge CLK) begin
        if (w_commit) begin
            r_mem[w_index] <= (r_mem[w_index] & ~w_wrMask) | (w_wrData & w_wrMask);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_addrErr  <= 1'b0;
            r_alignErr <= 1'b0;
            r_rdCount  <= 32'd0;
            r_wrCount  <= 32'd0;
        end else begin
            r_state    <= w_stateNext;
            r_cnt      <= w_cntNext;
            r_addrErr  <= w_complete & w_oor;
            r_alignErr <= w_complete & MemWrite_2DM & w_crossEnd;
            if (w_complete) begin
                if (MemWrite_2DM) begin
                    r_wrCount <= r_wrCount + 32'd1;
                end else begin
                    r_rdCount <= r_rdCount + 32'd1;
                end
            end
        end
    end

    assign data_read_fDM = w_oor ? 32'd0 : r_mem[w_index];
    assign stall_2MEM    = w_stall & ~RESET;
    assign addr_err      = r_addrErr;
    assign align_err     = r_alignErr;
    assign rd_count      = r_rdCount;
    assign wr_count      = r_wrCount;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a zero-wait instance driven by a vector table and random
// traffic against a byte-level model, plus a three-wait instance for handshake corners.
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        rst0;
    logic        rst3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        memRead;
    logic        memWrite;

    logic [31:0] rdata0, rdCount0, wrCount0;
    logic        stall0, addrErr0, alignErr0;
    logic [31:0] rdata3, rdCount3, wrCount3;
    logic        stall3, addrErr3, alignErr3;

    int checkCount = 0;
    int passCount  = 0;
    int modelRd    = 0;
    int modelWr    = 0;
    logic [7:0] refMem [int];

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
        logic        chkRd;
        logic [31:0] expRd;
        logic        expAlign;
        logic        expAddr;
    } vec_t;

    vec_t vecs [21];

    dmem_responder #(.ADDR_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .CLK(CLK), .RESET(rst0),
        .data_address_2DM(addr), .data_write_2DM(wdata), .data_write_size_2DM(size),
        .MemRead_2DM(memRead), .MemWrite_2DM(memWrite),
        .data_read_fDM(rdata0), .stall_2MEM(stall0),
        .addr_err(addrErr0), .align_err(alignErr0),
        .rd_count(rdCount0), .wr_count(wrCount0)
    );

    dmem_responder #(.ADDR_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .CLK(CLK), .RESET(rst3),
        .data_address_2DM(addr), .data_write_2DM(wdata), .data_write_size_2DM(size),
        .MemRead_2DM(memRead), .MemWrite_2DM(memWrite),
        .data_read_fDM(rdata3), .stall_2MEM(stall3),
        .addr_err(addrErr3), .align_err(alignErr3),
        .rd_count(rdCount3), .wr_count(wrCount3)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] a,
                                 input logic [31:0] d, input logic [1:0] s);
        memWrite = wr;
        memRead  = rd;
        addr     = a;
        wdata    = d;
        size     = s;
    endtask

    function automatic bit isOutOfRange(input logic [31:0] a);
        return a >= 32'(1024 * 4);
    endfunction

    task automatic modelWrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int k;
        int base;
        if (isOutOfRange(a)) return;
        k = (s == 2'd0) ? 4 : int'(s);
        base = int'(a) - int'(a) % 4;
        for (int j = 0; j < k; j++) begin
            if (int'(a) % 4 + j < 4) refMem[int'(a) + j] = d[8*(k-1-j) +: 8];
        end
        if (base < 0) $display("[TB] negative base");
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        int base;
        if (isOutOfRange(a)) return 32'd0;
        base = int'(a) - int'(a) % 4;
        return {refMem[base], refMem[base+1], refMem[base+2], refMem[base+3]};
    endfunction

    task automatic runCycle0(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] s, input logic chk,
                             input logic [31:0] expRd, input logic expAlign, input logic expAddr);
        @(negedge CLK);
        applyStimulus(wr, rd, a, d, s);
        #1;
        checkOutput("stall0", {31'b0, stall0}, 32'd0);
        if (chk) checkOutput("rdata0", rdata0, expRd);
        @(posedge CLK);
        #1;
        if (wr) modelWr++;
        else if (rd) modelRd++;
        checkOutput("alignErr0", {31'b0, alignErr0}, {31'b0, expAlign});
        checkOutput("addrErr0", {31'b0, addrErr0}, {31'b0, expAddr});
        checkOutput("rdCount0", rdCount0, 32'(modelRd));
        checkOutput("wrCount0", wrCount0, 32'(modelWr));
    endtask

    task automatic heldAccess3(input logic wr, input logic rd, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] s, input logic chk,
                               input logic [31:0] expRd);
        int stalls;
        bit done;
        stalls = 0;
        done   = 1'b0;
        @(negedge CLK);
        applyStimulus(wr, rd, a, d, s);
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (stall3) begin
                stalls++;
                @(negedge CLK);
            end else begin
                done = 1'b1;
            end
        end
        checkOutput("done3", {31'b0, done}, 32'd1);
        if (done && chk) checkOutput("rdata3", rdata3, expRd);
        checkOutput("stallCycles3", 32'(stalls), 32'd3);
        @(posedge CLK);
        #1;
    endtask

    initial begin : mainTest
        logic        wr, rd, chk, expAlign, expAddr;
        logic [31:0] a, d, expRd;
        logic [1:0]  s;
        int          op, k;

        vecs[0]  = '{1'b1, 1'b0, 32'h40,   32'h11223344, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 32'h40,   32'h0,        2'd0, 1'b1, 32'h11223344, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h40,   32'h0,        2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h41,   32'h000000AB, 2'd1, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h42,   32'h0000CDEF, 2'd2, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 32'h40,   32'h0,        2'd0, 1'b1, 32'h00ABCDEF, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h44,   32'h0,        2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h45,   32'h00112233, 2'd3, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h44,   32'h0,        2'd0, 1'b1, 32'h00112233, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h48,   32'h0,        2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h49,   32'hDEADBEEF, 2'd0, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h48,   32'h0,        2'd0, 1'b1, 32'h00DEADBE, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'h00,   32'h12345678, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h1000, 32'h0,        2'd0, 1'b1, 32'h0,        1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 32'h1000, 32'hFFFFFFFF, 2'd0, 1'b0, 32'h0,        1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 32'h00,   32'h0,        2'd0, 1'b1, 32'h12345678, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 32'h4C,   32'h55667788, 2'd0, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 32'h4C,   32'h0,        2'd0, 1'b1, 32'h55667788, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 32'h4F,   32'h0000A5C3, 2'd2, 1'b0, 32'h0,        1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 32'h4C,   32'h0,        2'd0, 1'b1, 32'h556677A5, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,    32'h0,        2'd0, 1'b0, 32'h0,        1'b0, 1'b0};

        // Both instances in reset with a read request asserted
        rst0 = 1'b1;
        rst3 = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h0, 2'd0);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rstStall0", {31'b0, stall0}, 32'd0);
        checkOutput("rstStall3", {31'b0, stall3}, 32'd0);
        checkOutput("rstAddrErr0", {31'b0, addrErr0}, 32'd0);
        checkOutput("rstAlignErr0", {31'b0, alignErr0}, 32'd0);
        checkOutput("rstRdCount0", rdCount0, 32'd0);
        checkOutput("rstWrCount0", wrCount0, 32'd0);
        checkOutput("rstRdCount3", rdCount3, 32'd0);
        checkOutput("rstWrCount3", wrCount3, 32'd0);

        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        rst0 = 1'b0;

        for (int i = 0; i < 21; i++) begin
            runCycle0(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].size,
                      vecs[i].chkRd, vecs[i].expRd, vecs[i].expAlign, vecs[i].expAddr);
        end

        // Random traffic over a small prefilled window, with occasional out-of-range hits
        for (int w = 0; w < 8; w++) begin
            a = 32'h100 + 32'(4 * w);
            d = $urandom;
            runCycle0(1'b1, 1'b0, a, d, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
            modelWrite(a, d, 2'd0);
        end
        for (int i = 0; i < 300; i++) begin
            op = int'($urandom_range(0, 7));
            wr = (op >= 5);
            rd = (op >= 2 && op <= 4) || op == 7;
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
            d  = $urandom;
            s  = 2'($urandom_range(0, 3));
            k  = (s == 2'd0) ? 4 : int'(s);
            expAlign = wr && (int'(a[1:0]) + k > 4);
            expAddr  = (wr || rd) && isOutOfRange(a);
            expRd    = modelRead(a);
            chk      = rd && !wr;
            runCycle0(wr, rd, a, d, s, chk, expRd, expAlign, expAddr);
            if (wr) modelWrite(a, d, s);
        end

        // Three-wait instance
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        rst0 = 1'b1;
        rst3 = 1'b0;

        heldAccess3(1'b1, 1'b0, 32'h80, 32'hCAFEF00D, 2'd0, 1'b0, 32'h0);
        checkOutput("wrCount3a", wrCount3, 32'd1);
        checkOutput("rdCount3a", rdCount3, 32'd0);
        checkOutput("alignErr3a", {31'b0, alignErr3}, 32'd0);
        checkOutput("addrErr3a", {31'b0, addrErr3}, 32'd0);
        heldAccess3(1'b0, 1'b1, 32'h80, 32'h0, 2'd0, 1'b1, 32'hCAFEF00D);
        checkOutput("rdCount3b", rdCount3, 32'd1);

        // Request dropped after one stall cycle
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0BADBEEF, 2'd0);
        #1;
        checkOutput("abortStallHigh3", {31'b0, stall3}, 32'd1);
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        #1;
        checkOutput("abortStallLow3", {31'b0, stall3}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("abortWrCount3", wrCount3, 32'd1);
        heldAccess3(1'b0, 1'b1, 32'h80, 32'h0, 2'd0, 1'b1, 32'hCAFEF00D);
        checkOutput("rdCount3c", rdCount3, 32'd2);

        // Reset while a write is waiting
        @(negedge CLK);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0BADBEEF, 2'd0);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("midStall3", {31'b0, stall3}, 32'd1);
        rst3 = 1'b1;
        #1;
        checkOutput("rstMidStall3", {31'b0, stall3}, 32'd0);
        checkOutput("rstMidRd3", rdCount3, 32'd0);
        checkOutput("rstMidWr3", wrCount3, 32'd0);
        checkOutput("rstMidAddrErr3", {31'b0, addrErr3}, 32'd0);
        checkOutput("rstMidAlignErr3", {31'b0, alignErr3}, 32'd0);
        @(negedge CLK);
        rst3 = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        heldAccess3(1'b0, 1'b1, 32'h80, 32'h0, 2'd0, 1'b1, 32'hCAFEF00D);
        checkOutput("rdCount3d", rdCount3, 32'd1);
        checkOutput("wrCount3d", wrCount3, 32'd0);

        // Out-of-range halfword that also crosses the word end
        heldAccess3(1'b1, 1'b0, 32'h1003, 32'h0000BEEF, 2'd2, 1'b0, 32'h0);
        checkOutput("oorAddrErr3", {31'b0, addrErr3}, 32'd1);
        checkOutput("oorAlignErr3", {31'b0, alignErr3}, 32'd1);
        checkOutput("oorWrCount3", wrCount3, 32'd1);
        @(negedge CLK);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
        @(posedge CLK);
        #1;
        checkOutput("pulseAddrErr3", {31'b0, addrErr3}, 32'd0);
        checkOutput("pulseAlignErr3", {31'b0, alignErr3}, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the MEM-stage data interface. It accepts word, byte, halfword and 3-byte (SWL/SWR) stores plus aligned word reads on the `*_2DM` bus and returns `data_read_fDM`. It inserts a programmable number of wait states through a stall handshake, and flags range and alignment faults. It sits between the MEM stage and the data array, and is also the bench model for that stage.

## Interface
- `ADDR_WORDS`, default 1024: array depth in 32-bit words; must be a power of two. `AW` = log2(`ADDR_WORDS`).
- `WAIT_CYCLES`, default 0: stall cycles inserted per access, legal range 0..15.
- `CLK` in, 1 bit: clock. All state changes on posedge.
- `RESET` in, 1 bit: asynchronous, active-high reset.
- `data_address_2DM` in, 32 bits: byte address. Reads use bits [AW+1:2]; writes also use [1:0] as the start lane.
- `data_write_2DM` in, 32 bits: store data, right-justified (n-byte store in the low n bytes).
- `data_write_size_2DM` in, 2 bits: 0 = 4 bytes, 1 = 1 byte, 2 = 2 bytes, 3 = 3 bytes.
- `MemRead_2DM` in, 1 bit: read request.
- `MemWrite_2DM` in, 1 bit: write request. Takes priority over a read.
- `data_read_fDM` out, 32 bits: aligned word at the request address, big-endian (lane 0 = bits [31:24]).
- `stall_2MEM` out, 1 bit: requester must hold its request stable.
- `addr_err` out, 1 bit: one-cycle pulse after a completed out-of-range access.
- `align_err` out, 1 bit: one-cycle pulse after a completed write that crossed the word end.
- `rd_count` out, 32 bits: completed reads, wraps at 2^32.
- `wr_count` out, 32 bits: completed writes, wraps at 2^32.

## Operation
- `req = MemRead_2DM | MemWrite_2DM`.
- An access is out of range when any bit in [31:AW+2] is set.
- Reads:
  - `data_read_fDM` is an asynchronous (combinational) read of `mem[addr[AW+1:2]]`.
  - It is 0 when the address is out of range.
  - It is valid in the completing cycle.
- Writes:
  - Commit on the completing posedge. Let k = size (size 0 means k=4) and o = addr[1:0].
  - Data byte j (j = 0 is the most significant of the k-byte field) goes to lane o+j.
  - Lanes above 3 are dropped, and `align_err` pulses when o+k > 4.
  - Untouched lanes keep their old contents.
  - An out-of-range write commits nothing.
- When both `MemRead_2DM` and `MemWrite_2DM` are high, the access is treated as a write and only `wr_count` increments.
- FSM (only when `WAIT_CYCLES` > 0):
  - IDLE: on req, go to WAIT with cnt = `WAIT_CYCLES`-1.
  - WAIT with cnt != 0: decrement cnt.
  - WAIT with cnt == 0: complete the access, go to IDLE.
  - WAIT with req low: abort, go to IDLE; no commit, no count.
- `stall_2MEM` = req & !(state == WAIT & cnt == 0). With `WAIT_CYCLES` = 0, every req completes in its own cycle and `stall_2MEM` = 0.
- Back-to-back requests: after a completion the FSM returns to IDLE, and a new request restarts the wait count.
- Changing the address or data while stalled is a protocol violation. The values present at the completing edge are used.
- Reset: FSM to IDLE, cnt = 0, `addr_err` = `align_err` = 0, `rd_count` = `wr_count` = 0. `stall_2MEM` is forced to 0 while `RESET` is high. The array is not cleared.
- Reset during WAIT drops the pending write uncommitted.

## Timing
- Latency from req to completion is `WAIT_CYCLES`+1 cycles, with `stall_2MEM` high for exactly `WAIT_CYCLES` cycles.
- Read data reflects the array before a same-edge write. A read in the cycle after a write sees the written value.
- `addr_err`, `align_err` and the counters update on the completing edge and are visible the next cycle.

## Test plan
- `WAIT_CYCLES`=0: SW 0x11223344 @0x40, then LW @0x40 → `data_read_fDM` = 0x11223344, `stall_2MEM` = 0 throughout, `wr_count` = 1, `rd_count` = 1.
- Byte/half lanes: SB 0xAB @0x41 then SH 0xCDEF @0x42 over 0 → word reads 0x00ABCDEF.
- SWL/SWR-style: size 3 data 0x00112233 @0x45 → lanes 1..3 = 11,22,33; SW 0xDEADBEEF @0x49 → lanes 1..3 = DE,AD,BE, `align_err` pulses once.
- `WAIT_CYCLES`=3: LW held → `stall_2MEM` high 3 cycles then low, data valid in cycle 4. Drop req after 1 stall cycle → returns to IDLE, no count. `RESET` mid-SW → no commit, all outputs 0.
- `ADDR_WORDS`=1024: LW @0x00001000 → `data_read_fDM` = 0, `addr_err` pulses; SW to the same address leaves the array unchanged.
